// File: rtl/spi0_slave_regfile.sv
// spi0_slave_regfile: SPI mode-0 slave exposing a 32x8 register file.
// The first byte of each transaction is a command byte:
//   cmd[7:3] = register address, cmd[1] = write when 1.
// While the command byte shifts in, MISO returns status_in.
// The data bytes that follow either write the register file or read it back.
// A local port lets fabric logic preload registers. An SPI write to the same
// register in the same cycle takes priority over the local write.
//
// Handshake: wr_pulse is a single-cycle strobe with no back-pressure.
// wr_addr and wr_data are valid in that cycle and hold until the next SPI write.
module spi0_slave_regfile #(
    parameter int AUTO_INC    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       spi0_SCLK,
    input  logic       spi0_MOSI,
    input  logic       spi0_SS_n,
    output logic       spi0_MISO,
    output logic       spi0_MISO_oe,
    input  logic [7:0] status_in,
    input  logic       loc_we,
    input  logic [4:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic       wr_pulse,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int LAST = SYNC_STAGES - 1;

    // Synchronizer chains. The SS_n chain resets high so that leaving reset
    // can never look like a slave-select fall.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ssn_sync_q,  ssn_sync_d;
    logic                   sclk_last_q, sclk_last_d;
    logic                   ssn_last_q,  ssn_last_d;

    state_e      state_q,    state_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [6:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [4:0]  addr_q,     addr_d;
    logic        is_wr_q,    is_wr_d;
    logic        oe_q,       oe_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [4:0]  wr_addr_q,  wr_addr_d;
    logic [7:0]  wr_data_q,  wr_data_d;
    logic [7:0]  regs_q [32];
    logic [7:0]  regs_d [32];

    logic       sclk_rise, sclk_fall, ssn_rise, ssn_fall, mosi_s;
    logic [7:0] rx_byte;

    // Edge detection from the last two synchronized samples.
    always_comb begin
        sclk_rise = sclk_sync_q[LAST] & ~sclk_last_q;
        sclk_fall = ~sclk_sync_q[LAST] & sclk_last_q;
        ssn_rise  = ssn_sync_q[LAST] & ~ssn_last_q;
        ssn_fall  = ~ssn_sync_q[LAST] & ssn_last_q;
        mosi_s    = mosi_sync_q[LAST];
        rx_byte   = {rx_shift_q, mosi_s};
    end

    // Next-state logic: synchronizers, transaction FSM, shifters and register file.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi0_SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi0_MOSI};
        ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0],  spi0_SS_n};
        sclk_last_d = sclk_sync_q[LAST];
        ssn_last_d  = ssn_sync_q[LAST];

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        addr_d     = addr_q;
        is_wr_d    = is_wr_q;
        oe_d       = oe_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;

        // The local write is applied first so that an SPI write to the same
        // register in the same cycle overrides it.
        if (loc_we) begin
            regs_d[loc_addr] = loc_wdata;
        end

        if (ssn_rise) begin
            // End of transaction. A partial byte is simply dropped.
            state_d    = ST_IDLE;
            oe_d       = 1'b0;
            tx_shift_d = 8'h00;
            bit_cnt_d  = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ssn_fall) begin
                        tx_shift_d = status_in;
                        oe_d       = 1'b1;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d  = rx_byte[7:3];
                            is_wr_d = rx_byte[1];
                            state_d = ST_DATA;
                        end
                    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
                        // The status byte is already loaded, so only shift here.
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_byte[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (is_wr_q) begin
                                regs_d[addr_q] = rx_byte;
                                wr_pulse_d     = 1'b1;
                                wr_addr_d      = addr_q;
                                wr_data_d      = rx_byte;
                            end
                            if (AUTO_INC != 0) begin
                                addr_d = addr_q + 5'd1;
                            end
                        end
                    end else if (sclk_fall) begin
                        // At a byte boundary the outgoing byte is captured here,
                        // so later writes to that register do not change the byte
                        // already being shifted out.
                        if (bit_cnt_q == 3'd0) begin
                            tx_shift_d = is_wr_q ? 8'h00 : regs_q[addr_q];
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with asynchronous reset. The register file is also cleared.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ssn_sync_q  <= '1;
            sclk_last_q <= 1'b0;
            ssn_last_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= 8'h00;
            addr_q      <= 5'd0;
            is_wr_q     <= 1'b0;
            oe_q        <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ssn_sync_q  <= ssn_sync_d;
            sclk_last_q <= sclk_last_d;
            ssn_last_q  <= ssn_last_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            addr_q      <= addr_d;
            is_wr_q     <= is_wr_d;
            oe_q        <= oe_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign spi0_MISO    = tx_shift_q[7];
    assign spi0_MISO_oe = oe_q;
    assign wr_pulse     = wr_pulse_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_spi0_slave_regfile.sv
// Directed bench for spi0_slave_regfile. The bench acts as a mode-0 SPI master.
// Two instances share the SPI pins:
//   dut       : AUTO_INC=1
//   dut_fixed : AUTO_INC=0
module tb_spi0_slave_regfile;

  localparam int HALF = 8;   // clk cycles per SCLK half period

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic [7:0] status_in;
  logic       loc_we;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata;

  logic       miso_a, oe_a, wr_pulse, busy;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] dbg_state;

  logic       miso_b, oe_b, wr_pulse_b, busy_b;
  logic [4:0] wr_addr_b;
  logic [7:0] wr_data_b;
  logic [1:0] dbg_state_b;

  int err_cnt;
  int chk_cnt;
  logic [12:0] exp_q[$];   // expected {addr, data} of SPI writes
  logic [7:0]  ra, rb;

  spi0_slave_regfile #(.AUTO_INC(1), .SYNC_STAGES(2)) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .spi0_SCLK    (sclk),
    .spi0_MOSI    (mosi),
    .spi0_SS_n    (ss_n),
    .spi0_MISO    (miso_a),
    .spi0_MISO_oe (oe_a),
    .status_in    (status_in),
    .loc_we       (loc_we),
    .loc_addr     (loc_addr),
    .loc_wdata    (loc_wdata),
    .wr_pulse     (wr_pulse),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  spi0_slave_regfile #(.AUTO_INC(0), .SYNC_STAGES(2)) dut_fixed (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .spi0_SCLK    (sclk),
    .spi0_MOSI    (mosi),
    .spi0_SS_n    (ss_n),
    .spi0_MISO    (miso_b),
    .spi0_MISO_oe (oe_b),
    .status_in    (status_in),
    .loc_we       (loc_we),
    .loc_addr     (loc_addr),
    .loc_wdata    (loc_wdata),
    .wr_pulse     (wr_pulse_b),
    .wr_addr      (wr_addr_b),
    .wr_data      (wr_data_b),
    .busy         (busy_b),
    .dbg_state    (dbg_state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver tasks
  task automatic ss_low();
    ss_n = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_high();
    tick(HALF);
    ss_n = 1'b1;
    tick(HALF);
  endtask

  // Shift nbits of tx (MSB first). MISO is captured just before each rising edge.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx_a, output logic [7:0] rx_b);
    rx_a = 8'h00;
    rx_b = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      tick(HALF);
      rx_a[i] = miso_a;
      rx_b[i] = miso_b;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  // scoreboard for write pulses
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_pulse", 32'd1, 32'd0);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, wr_addr}, {27'd0, e[12:8]});
        check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    err_cnt   = 0;
    chk_cnt   = 0;
    rst       = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    ss_n      = 1'b1;
    status_in = 8'h00;
    loc_we    = 1'b0;
    loc_addr  = 5'd0;
    loc_wdata = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2);

    // reset state
    check("rst_miso", {31'd0, miso_a}, 32'd0);
    check("rst_oe", {31'd0, oe_a}, 32'd0);
    check("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // write burst: addr 5 <- 0x11, addr 6 <- 0x22
    status_in = 8'h3C;
    exp_q.push_back({5'd5, 8'h11});
    exp_q.push_back({5'd6, 8'h22});
    ss_low();
    check("burst_oe", {31'd0, oe_a}, 32'd1);
    check("burst_busy", {31'd0, busy}, 32'd1);
    xfer(8'h2A, 8, ra, rb);
    check("burst_status", {24'd0, ra}, 32'h3C);
    xfer(8'h11, 8, ra, rb);
    check("burst_miso1", {24'd0, ra}, 32'h00);
    xfer(8'h22, 8, ra, rb);
    check("burst_miso2", {24'd0, ra}, 32'h00);
    ss_high();
    check("burst_pulses_done", exp_q.size(), 32'd0);

    // read back from addr 5
    status_in = 8'hA5;
    ss_low();
    xfer(8'h28, 8, ra, rb);
    check("read_status", {24'd0, ra}, 32'hA5);
    xfer(8'h00, 8, ra, rb);
    check("read_reg5", {24'd0, ra}, 32'h11);
    xfer(8'h00, 8, ra, rb);
    check("read_reg6", {24'd0, ra}, 32'h22);
    ss_high();

    // wrap at addr 31
    status_in = 8'h5A;
    exp_q.push_back({5'd31, 8'h7E});
    exp_q.push_back({5'd0, 8'h81});
    ss_low();
    xfer(8'hFA, 8, ra, rb);
    xfer(8'h7E, 8, ra, rb);
    xfer(8'h81, 8, ra, rb);
    ss_high();
    ss_low();
    xfer(8'hF8, 8, ra, rb);
    check("wrap_status", {24'd0, ra}, 32'h5A);
    xfer(8'h00, 8, ra, rb);
    check("wrap_reg31_inc", {24'd0, ra}, 32'h7E);
    check("wrap_reg31_fixed", {24'd0, rb}, 32'h81);
    xfer(8'h00, 8, ra, rb);
    check("wrap_reg0_inc", {24'd0, ra}, 32'h81);
    check("wrap_reg31_fixed_again", {24'd0, rb}, 32'h81);
    ss_high();

    // abort after 5 data bits to addr 2
    ss_low();
    xfer(8'h12, 8, ra, rb);
    xfer(8'hFF, 5, ra, rb);
    ss_high();
    check("abort_oe", {31'd0, oe_a}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_miso", {31'd0, miso_a}, 32'd0);
    status_in = 8'hC3;
    ss_low();
    xfer(8'h10, 8, ra, rb);
    check("abort_next_status", {24'd0, ra}, 32'hC3);
    xfer(8'h00, 8, ra, rb);
    check("abort_reg2", {24'd0, ra}, 32'h00);
    ss_high();

    // collision: local write of 0x55 lands in the same cycle as SPI write of 0x99 to addr 3
    exp_q.push_back({5'd3, 8'h99});
    ss_low();
    xfer(8'h1A, 8, ra, rb);
    xfer(8'h99, 7, ra, rb);
    mosi = 1'b1;
    tick(HALF);
    sclk = 1'b1;
    tick(2);
    loc_we    = 1'b1;
    loc_addr  = 5'd3;
    loc_wdata = 8'h55;
    tick(1);
    loc_we = 1'b0;
    tick(HALF - 3);
    sclk = 1'b0;
    ss_high();
    check("coll_pulses_done", exp_q.size(), 32'd0);
    loc_we    = 1'b1;
    loc_addr  = 5'd4;
    loc_wdata = 8'h66;
    tick(1);
    loc_we = 1'b0;
    tick(2);
    ss_low();
    xfer(8'h18, 8, ra, rb);
    xfer(8'h00, 8, ra, rb);
    check("coll_reg3", {24'd0, ra}, 32'h99);
    xfer(8'h00, 8, ra, rb);
    check("local_reg4", {24'd0, ra}, 32'h66);
    ss_high();

    // asynchronous reset in the middle of a data byte
    ss_low();
    xfer(8'h3A, 8, ra, rb);
    xfer(8'hF0, 3, ra, rb);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_miso", {31'd0, miso_a}, 32'd0);
    check("mid_rst_oe", {31'd0, oe_a}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    check("mid_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("mid_rst_wr_data", {24'd0, wr_data}, 32'd0);
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    status_in = 8'h96;
    ss_low();
    xfer(8'h28, 8, ra, rb);
    check("post_rst_status", {24'd0, ra}, 32'h96);
    xfer(8'h00, 8, ra, rb);
    check("post_rst_reg5", {24'd0, ra}, 32'h00);
    xfer(8'h00, 8, ra, rb);
    check("post_rst_reg6", {24'd0, ra}, 32'h00);
    ss_high();
    check("final_pulses_done", exp_q.size(), 32'd0);

    // report
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi0_slave_regfile.md
Name: spi0_slave_regfile

Overview:
- SPI slave responder for the far end of the platform's spi0 master port (spi0_SCLK/MOSI/SS_n in, spi0_MISO out).
- Emulates a MAX3421E-style peripheral for bench and loopback bring-up: a 32x8 register file is read and written over SPI.
- A status byte is returned during the command phase.
- A local port lets fabric logic preload registers and observe SPI writes.

Parameters:
- AUTO_INC, 1, 1 = register address auto-increments after each data byte (31 wraps to 0); 0 = address fixed for the whole transaction.
- SYNC_STAGES, 2, number of synchronizer flops on SCLK, MOSI and SS_n (minimum 2).

Ports:
- clk_clk  in  1  system clock; must be at least 8x SCLK frequency.
- reset_reset  in  1  asynchronous, active-high reset.
- spi0_SCLK  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
- spi0_MOSI  in  1  master-out data, MSB first.
- spi0_SS_n  in  1  active-low slave select.
- spi0_MISO  out  1  slave-out data, MSB first.
- spi0_MISO_oe  out  1  MISO drive enable; high while SS_n is low (synchronized).
- status_in  in  8  byte returned during the command byte; sampled at SS_n fall.
- loc_we  in  1  local register write strobe.
- loc_addr  in  5  local write address.
- loc_wdata  in  8  local write data.
- wr_pulse  out  1  one-cycle pulse for each SPI-written byte.
- wr_addr  out  5  address of the SPI write; valid with wr_pulse.
- wr_data  out  8  data of the SPI write; valid with wr_pulse.
- busy  out  1  high while a transaction is active (state is not IDLE).

Behaviour:
- Reset values: spi0_MISO=0, spi0_MISO_oe=0, wr_pulse=0, wr_addr=0, wr_data=0, busy=0, all registers 0x00, state IDLE, bit_cnt=0.
- Input sync: SCLK, MOSI and SS_n each pass through SYNC_STAGES flops. Edges are detected from the last two synchronized samples. All SPI actions occur on the clk_clk cycle the edge is detected, SYNC_STAGES+1 cycles after the pin change.
- Command byte format: cmd[7:3] = register address; cmd[1] = 1 for write, 0 for read; cmd[2] and cmd[0] are ignored.
- States:
  - IDLE: on SS_n fall, load tx_shift = status_in, drive MISO = status_in[7], set MISO_oe=1 and bit_cnt=0, go to CMD.
  - CMD: on each SCLK rise, shift MOSI into rx_shift and increment bit_cnt. On the 8th rise, latch addr = cmd[7:3] and the direction bit, then go to DATA.
  - DATA: on each SCLK rise, shift MOSI in. On the 8th rise:
    - write: reg[addr] <= byte; wr_pulse=1 for one cycle with wr_addr/wr_data.
    - read: data discarded.
    - then, if AUTO_INC, addr <= addr+1 (mod 32).
- MISO update on SCLK fall:
  - bit_cnt == 0 (byte boundary): load tx_shift with reg[addr] for reads or 0x00 for writes and drive its bit7.
  - otherwise: shift tx_shift left and drive the new bit7.
  - Mode 0 timing: data changes on the fall and is sampled by the master on the rise.
- Read data is captured at the load edge. An SPI or local write to the same address after the load does not alter the byte in flight.
- SS_n rise in any state: return to IDLE; MISO_oe=0 and MISO=0 in the same cycle; a partial byte (bit_cnt != 0) is discarded with no write and no pulse.
- A transaction containing only a command byte performs no register access.
- Collision: an SPI write and loc_we to the same register in the same cycle: the SPI write wins and the local write is dropped. Different addresses: both complete.
- loc_we does not raise wr_pulse.
- SCLK edges while SS_n is high are ignored.
- Asynchronous reset mid-transaction: immediate return to reset values; the register file is cleared.

Test Plan:
- Write burst: SS low, cmd 0x2A (addr 5, write), data 0x11, 0x22, SS high -> reg5=0x11, reg6=0x22; two wr_pulses, with (5,0x11) then (6,0x22); MISO shows status_in then 0x00, 0x00.
- Read back: status_in=0xA5; SS low, cmd 0x28 (addr 5, read), two dummy bytes -> MISO bytes 0xA5, 0x11, 0x22; no wr_pulse.
- Wrap: AUTO_INC=1, write at addr 31 with data 0x7E, 0x81 -> reg31=0x7E, reg0=0x81. With AUTO_INC=0, the same stimulus gives reg31=0x81.
- Abort: cmd 0x12 (addr 2, write), then 5 data bits followed by SS high -> reg2 unchanged, no wr_pulse, MISO_oe=0, busy=0; the next transaction decodes correctly.
- Collision: loc_we addr 3 with 0x55 in the same cycle as the SPI write of 0x99 to addr 3 -> reg3=0x99. Then loc_we addr 4 with 0x66 and an SPI read of addr 4 -> MISO returns 0x66.
- Reset: assert reset_reset mid-DATA -> all outputs 0 next cycle, registers read 0x00 in the following transaction.
